// File: rtl/ofdm_sync_pkg.sv
// Shared OFDM sync definitions: the 64-entry sign coefficient set used by both the
// TX preamble generator and the RX sign correlator, the generator FSM encoding, and sample mapping.
package ofdm_sync_pkg;

    localparam int SYNC_LEN = 64;

    // Element k holds {imag sign, real sign} of sync sample k (1 = negative)
    localparam logic [SYNC_LEN-1:0][1:0] SYNC_COEFF = 128'hD2C6_5A39_E18B_74F0_3C96_A5E1_0F87_2B4D;

`ifdef OFDM_PRE_CP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_CP, ST_PRE, ST_DONE} pre_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DONE} pre_state_e;
`endif

    function automatic int sign_to_sample(input logic neg, input int amp);
        return neg ? -amp : amp;
    endfunction

endpackage

// File: rtl/ofdm_preamble_gen_if.sv
// Control and sample-stream signals between the preamble generator and its user.
interface ofdm_preamble_gen_if #(parameter int DW = 16);

    logic                 start;
    logic                 abort;
    logic                 out_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic [1:0]           sync_sign;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, abort, out_ready,
        output out_valid, out_re, out_im, sync_sign, busy, done
    );

    modport slave (
        output start, abort, out_ready,
        input  out_valid, out_re, out_im, sync_sign, busy, done
    );

endinterface

// File: rtl/preamble_sign_rom.sv
// Combinational index -> {imag sign, real sign} lookup into the sync coefficient set.
module preamble_sign_rom
    import ofdm_sync_pkg::*;
(
    input  logic [5:0] idx,
    output logic [1:0] sign
);

    assign sign = SYNC_COEFF[idx];

endmodule

// File: rtl/ofdm_preamble_gen.sv
// OFDM TX preamble generator: NREP back-to-back copies of the 64-sample sync sequence.
// Optional cyclic prefix (last CP_LEN samples first) when OFDM_PRE_CP_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start, outputs zero
// CP      | emitting cyclic prefix samples (OFDM_PRE_CP_EN only)
// PRE     | emitting sync samples, idx 0..63, rep 0..NREP-1
// DONE    | one-cycle done pulse, then back to IDLE
module ofdm_preamble_gen
    import ofdm_sync_pkg::*;
#(
    parameter int DW     = 16,
    parameter int AMP    = 5793,
    parameter int NREP   = 2,
    parameter int CP_LEN = 16
) (
    input  logic                clk,
    input  logic                rst,
    ofdm_preamble_gen_if.master bus
);

    localparam logic [5:0] IDX_LAST = 6'(SYNC_LEN - 1);
    localparam logic [3:0] REP_LAST = 4'(NREP - 1);
`ifdef OFDM_PRE_CP_EN
    localparam logic [5:0] CP_FIRST = 6'(SYNC_LEN - CP_LEN);
`endif

    pre_state_e state, state_nxt;
    logic [5:0] idx, idx_nxt;
    logic [3:0] rep, rep_nxt;

    logic                 valid_q, busy_q, done_q;
    logic signed [DW-1:0] re_q, im_q;
    logic [1:0]           sign_q;

    logic                 valid_d, done_d;
    logic signed [DW-1:0] re_d, im_d;
    logic [1:0]           sign_d;
    logic [1:0]           rom_sign;
    logic                 accept;

    assign accept = valid_q && bus.out_ready;

    // Looked up on the next index so the registered sample lines up with the new state
    preamble_sign_rom u_rom (
        .idx  (idx_nxt),
        .sign (rom_sign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            rep     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            sign_q  <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            rep     <= rep_nxt;
            valid_q <= valid_d;
            busy_q  <= valid_d;
            done_q  <= done_d;
            re_q    <= re_d;
            im_q    <= im_d;
            sign_q  <= sign_d;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        rep_nxt   = rep;
        if (state != ST_IDLE && bus.abort) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            rep_nxt   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
`ifdef OFDM_PRE_CP_EN
                        state_nxt = ST_CP;
                        idx_nxt   = CP_FIRST;
`else
                        state_nxt = ST_PRE;
                        idx_nxt   = '0;
`endif
                        rep_nxt   = '0;
                    end
                end
`ifdef OFDM_PRE_CP_EN
                ST_CP: begin
                    if (accept) begin
                        if (idx == IDX_LAST) begin
                            state_nxt = ST_PRE;
                            idx_nxt   = '0;
                            rep_nxt   = '0;
                        end else begin
                            idx_nxt = idx + 6'd1;
                        end
                    end
                end
`endif
                ST_PRE: begin
                    if (accept) begin
                        idx_nxt = idx + 6'd1;
                        if (idx == IDX_LAST) begin
                            if (rep == REP_LAST) begin
                                state_nxt = ST_DONE;
                                rep_nxt   = '0;
                            end else begin
                                rep_nxt = rep + 4'd1;
                            end
                        end
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                default: begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                    rep_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        valid_d = 1'b0;
        done_d  = (state_nxt == ST_DONE);
        re_d    = '0;
        im_d    = '0;
        sign_d  = '0;
`ifdef OFDM_PRE_CP_EN
        if (state_nxt == ST_PRE || state_nxt == ST_CP) begin
`else
        if (state_nxt == ST_PRE) begin
`endif
            valid_d = 1'b1;
            sign_d  = rom_sign;
            re_d    = DW'(sign_to_sample(rom_sign[0], AMP));
            im_d    = DW'(sign_to_sample(rom_sign[1], AMP));
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_re    = re_q;
    assign bus.out_im    = im_q;
    assign bus.sync_sign = sign_q;

endmodule

// File: tb/tb_ofdm_preamble_gen.sv
// Directed bench for ofdm_preamble_gen: reset, full bursts, backpressure, abort, start collisions.
module tb_ofdm_preamble_gen;

`ifdef OFDM_PRE_CP_EN
    localparam int CP = 16;
`else
    localparam int CP = 0;
`endif
    localparam int NSAMP = 128 + CP;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    logic [63:0][1:0] coeff = 128'hD2C6_5A39_E18B_74F0_3C96_A5E1_0F87_2B4D;
    logic [15:0] pos_amp = 16'h16A1;
    logic [15:0] neg_amp = 16'hE95F;

    always #5 clk = ~clk;

    ofdm_preamble_gen_if #(.DW(16)) bus ();

    ofdm_preamble_gen #(.DW(16), .AMP(5793), .NREP(2), .CP_LEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] exp_word(input int k);
        int ci;
        logic [1:0] c;
        ci = (k < CP) ? (64 - CP + k) : ((k - CP) % 64);
        c = coeff[ci];
        return {1'b1, c, c[0] ? neg_amp : pos_amp, c[1] ? neg_amp : pos_amp};
    endfunction

    function automatic logic [34:0] obs_word();
        return {bus.out_valid, bus.sync_sign, bus.out_re, bus.out_im};
    endfunction

    function automatic logic [34:0] obs_stat();
        return {33'b0, bus.busy, bus.done};
    endfunction

    // Starts a burst and checks samples 0..upto-1, optionally stalling or pulsing start mid-burst
    task automatic run_burst(input int upto, input int stall_at, input int start_at);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check("busy_first", obs_stat(), 35'b10);
        for (int k = 0; k < upto; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("sample%0d", k), obs_word(), exp_word(k));
            bus.start = (k == start_at);
            if (k == stall_at) begin
                bus.out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check($sformatf("stall%0d", j), obs_word(), exp_word(k));
                end
                bus.out_ready = 1'b1;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic check_done_tail(input string tag);
        @(negedge clk);
        check({tag, "_done_word"}, obs_word(), 35'h0);
        check({tag, "_done_stat"}, obs_stat(), 35'b01);
        @(negedge clk);
        check({tag, "_idle_stat"}, obs_stat(), 35'b00);
    endtask

    initial begin
        bus.start     = 1'b1;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;

        // reset held with start high
        repeat (3) @(negedge clk);
        check("rst_word", obs_word(), 35'h0);
        check("rst_stat", obs_stat(), 35'b00);
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_word", obs_word(), 35'h0);
        check("post_rst_stat", obs_stat(), 35'b00);

        // full burst, no backpressure
        run_burst(NSAMP, -1, -1);
        check_done_tail("burst");

        // backpressure at preamble idx 10 plus a stray start mid-burst
        run_burst(NSAMP, CP + 10, CP + 50);
        check_done_tail("stall");

        // abort at rep 1, idx 37
        run_burst(CP + 64 + 37 + 1, -1, -1);
        bus.abort = 1'b1;
        @(negedge clk) bus.abort = 1'b0;
        check("abort_word", obs_word(), 35'h0);
        check("abort_stat", obs_stat(), 35'b00);
        @(negedge clk);
        check("abort_nodone", obs_stat(), 35'b00);

        // restart after abort begins at sample 0
        run_burst(4, -1, -1);
        bus.abort = 1'b1;
        @(negedge clk) bus.abort = 1'b0;
        check("abort2_word", obs_word(), 35'h0);

        // start and abort together in IDLE
        @(negedge clk) begin
            bus.start = 1'b1;
            bus.abort = 1'b1;
        end
        @(negedge clk) begin
            bus.start = 1'b0;
            bus.abort = 1'b0;
        end
        check("collide_word", obs_word(), 35'h0);
        check("collide_stat", obs_stat(), 35'b00);
        @(negedge clk);
        check("collide_hold", obs_word(), 35'h0);

        // a clean burst still works afterwards
        run_burst(NSAMP, -1, -1);
        check_done_tail("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ofdm_preamble_gen.md
Name: ofdm_preamble_gen

Overview:
- Transmit-side preamble generator for the OFDM PHY. It emits the 64-sample known synchronisation sequence NREP times as signed I/Q samples toward the TX front end, with a valid/ready handshake.
- It also drives a 2-bit sign output in the receiver's sign-correlator input format (bit1 = imag sign, bit0 = real sign), so a receiver-side sign correlator can be fed from it in loopback.
- It sits ahead of the data-symbol path; `done` hands the stream over to payload.

Parameters:
- DW, 16, signed sample width of out_re/out_im.
- AMP, 5793, positive magnitude mapped to each sample (must fit DW-1 bits).
- NREP, 2, number of back-to-back repetitions of the 64-sample sequence (1..15).
- CP_LEN, 16, cyclic-prefix length; used only when OFDM_PRE_CP_EN is defined (1..63).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a preamble burst
- abort  in  1  synchronous cancel of the current burst
- out_ready  in  1  downstream accepts the current sample
- out_valid  out  1  out_re/out_im/sync_sign are valid
- out_re  out  DW  signed real sample
- out_im  out  DW  signed imaginary sample
- sync_sign  out  2  [1] imag sign, [0] real sign of the current sample (1 = negative)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after the last sample is accepted

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; idx = 0; rep = 0.
  - out_valid, busy, done = 0; out_re, out_im, sync_sign = 0.
- FSM states: IDLE, CP (only with the macro), PRE, DONE.
- IDLE + start (abort low):
  - Next cycle: state PRE (or CP), out_valid = 1, busy = 1, first sample presented.
  - Latency from start to first sample is 1 cycle.
- start in any state other than IDLE is ignored. start and abort together in IDLE: abort wins and the block stays IDLE.
- Sample mapping from SYNC_COEFF[idx]:
  - bit0 = 0 → out_re = +AMP; bit0 = 1 → out_re = -AMP.
  - bit1 maps to out_im the same way.
  - sync_sign = SYNC_COEFF[idx].
- Outputs are registered. A sample advances only on out_valid && out_ready.
- While out_ready is low, all outputs hold stable; no sample is skipped or repeated.
- PRE:
  - idx counts 0..63 and wraps to 0 on accept of idx 63, while rep increments.
  - On accept of idx 63 with rep = NREP-1: state DONE, out_valid = 0.
- DONE: for one cycle done = 1 and busy = 0; the next state is IDLE. done is never asserted otherwise.
- abort (any non-IDLE state): next cycle state IDLE, out_valid = 0, busy = 0, done = 0, counters cleared. Sample outputs go to 0.
- Total samples accepted per burst: 64*NREP (+CP_LEN with the macro).

Optional Feature:
- Macro OFDM_PRE_CP_EN.
- Defined:
  - Start enters state CP first and emits SYNC_COEFF[64-CP_LEN .. 63] with the same handshake.
  - After the last CP accept it enters PRE at idx 0, rep 0.
  - abort also applies in CP.
- Undefined: no CP state and no CP counter logic; start goes directly to PRE; CP_LEN is unused.

Decomposition:
- Package ofdm_sync_pkg holds:
  - SYNC_LEN = 64;
  - the SYNC_COEFF constant array (64 × 2-bit, the same coefficient set the receiver correlator uses);
  - the FSM state enum;
  - a sign-to-sample mapping function.
- One natural sub-module, preamble_sign_rom: combinational 6-bit index → 2-bit sign lookup from SYNC_COEFF.

Test Plan:
1. Reset check: hold rst low with start = 1 and out_ready = 1 → all outputs 0, no valid. Release rst → IDLE, outputs unchanged until start.
2. Full burst, NREP = 2, out_ready = 1:
   - start → out_valid high from the next cycle for exactly 128 cycles.
   - Sample k has sync_sign = SYNC_COEFF[k mod 64] and out_re/out_im = ±5793 per mapping.
   - done pulses once in the cycle after the 128th accept; busy then falls.
3. Backpressure: drop out_ready for 3 cycles at idx 10 → outputs frozen on idx 10 for those cycles; 128 samples are still accepted in order; done is 3 cycles later than in test 2.
4. Abort: assert abort at rep 1, idx 37 → next cycle out_valid = 0, busy = 0, no done. A new start restarts at rep 0, idx 0.
5. Start collisions: start during PRE → ignored, sequence unaffected; start + abort in IDLE → stays IDLE, out_valid = 0.
6. With OFDM_PRE_CP_EN and CP_LEN = 16: the first 16 samples equal SYNC_COEFF[48..63], followed by 128 preamble samples (144 total); done follows the 144th accept.
